// File: rtl/hs32_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// hs32_mem_arbiter_pkg
// Shared definitions for the HS32 memory arbiter and the bus models that sit
// next to it: FSM state encodings and the default read data returned on a
// timed-out bus transaction.
// ---------------------------------------------------------------------------
package hs32_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [31:0] HS32_ERRDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/hs32_bus_timer.sv
// ---------------------------------------------------------------------------
// hs32_bus_timer
// Counts memory-bus wait cycles of the current transaction and flags expiry
// on the wait cycle that brings the count to TIMEOUT. TIMEOUT = 0 disables
// the timer entirely (expired_o tied low, no counter state).
//
// Ports:
//   clk        in  system clock
//   rstn       in  asynchronous active-low reset
//   run_i      in  a bus transaction is in flight
//   hit_i      in  memory completed this cycle (m_rdy)
//   expired_o  out this cycle is the TIMEOUT-th wait cycle without hit_i
// ---------------------------------------------------------------------------
module hs32_bus_timer #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic run_i,
  input  logic hit_i,
  output logic expired_o
);

  generate
    if (TIMEOUT > 0) begin : g_timer
      localparam int CW = $clog2(TIMEOUT + 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          last_wait;

      // Holding TIMEOUT-1 means the current wait cycle is the TIMEOUT-th.
      assign last_wait = (cnt_q == CW'(TIMEOUT - 1));
      assign expired_o = run_i && !hit_i && last_wait;

      always_comb begin
        cnt_d = cnt_q;
        if (!run_i || hit_i || last_wait) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_no_timer
      logic unused_no_timer;
      assign unused_no_timer = ^{clk, rstn, run_i, hit_i};
      assign expired_o       = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/hs32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// hs32_mem_arbiter
// Arbitrates the HS32 fetch (read-only) and execute (read/write) ports onto a
// single memory bus with one outstanding transaction. Ties alternate using
// the last_x bit (execute wins the first tie after reset). Every transaction
// passes through RESP, which ignores requests, so a served client gets one
// cycle to present its next address before IDLE samples it again.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   f_addr, f_req              fetch request
//   f_dtr, f_rdy, f_err        fetch response (rdy is a one-cycle pulse)
//   x_addr, x_dtw, x_rw, x_req execute request (x_rw 1 = write)
//   x_dtr, x_rdy, x_err        execute response (rdy is a one-cycle pulse)
//   m_addr, m_dtw, m_rw, m_req memory bus request, held until m_rdy
//   m_dtr, m_rdy               memory bus response
// All outputs are registered.
// ---------------------------------------------------------------------------
module hs32_mem_arbiter
  import hs32_mem_arbiter_pkg::*;
#(
  parameter int          TIMEOUT = 0,
  parameter logic [31:0] ERRDATA = HS32_ERRDATA
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] f_addr,
  input  logic        f_req,
  output logic [31:0] f_dtr,
  output logic        f_rdy,
  input  logic [31:0] x_addr,
  input  logic [31:0] x_dtw,
  input  logic        x_rw,
  input  logic        x_req,
  output logic [31:0] x_dtr,
  output logic        x_rdy,
  output logic        x_err,
  output logic        f_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_dtw,
  output logic        m_rw,
  output logic        m_req,
  input  logic [31:0] m_dtr,
  input  logic        m_rdy
);

  arb_state_e  state_q;
  logic        last_x_q;
  logic        srv_x_q;
  logic        err_q;
  logic [31:0] f_dtr_q;
  logic [31:0] x_dtr_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_dtw_q;
  logic        f_rdy_q;
  logic        x_rdy_q;
  logic        f_err_q;
  logic        x_err_q;
  logic        m_rw_q;
  logic        m_req_q;
  logic        busy;
  logic        tmo;
  logic        grant_x;

  assign busy    = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  // Execute wins when alone, or on a tie when fetch was not the last... i.e.
  // when the last served port was fetch (last_x_q = 0).
  assign grant_x = x_req && (!f_req || !last_x_q);

  hs32_bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .run_i     (busy),
    .hit_i     (m_rdy),
    .expired_o (tmo)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      last_x_q <= 1'b0;
      srv_x_q  <= 1'b0;
      err_q    <= 1'b0;
      f_dtr_q  <= '0;
      x_dtr_q  <= '0;
      m_addr_q <= '0;
      m_dtw_q  <= '0;
      f_rdy_q  <= 1'b0;
      x_rdy_q  <= 1'b0;
      f_err_q  <= 1'b0;
      x_err_q  <= 1'b0;
      m_rw_q   <= 1'b0;
      m_req_q  <= 1'b0;
    end else begin
      // Completion flags are pulses unless RESP sets them below.
      f_rdy_q <= 1'b0;
      x_rdy_q <= 1'b0;
      f_err_q <= 1'b0;
      x_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_x) begin
            m_addr_q <= x_addr;
            m_dtw_q  <= x_dtw;
            m_rw_q   <= x_rw;
            m_req_q  <= 1'b1;
            srv_x_q  <= 1'b1;
            state_q  <= ST_EXEC;
          end else if (f_req) begin
            m_addr_q <= f_addr;
            m_dtw_q  <= '0;
            m_rw_q   <= 1'b0;
            m_req_q  <= 1'b1;
            srv_x_q  <= 1'b0;
            state_q  <= ST_FETCH;
          end
        end
        ST_FETCH, ST_EXEC: begin
          if (m_rdy) begin
            if (srv_x_q) x_dtr_q <= m_dtr;
            else         f_dtr_q <= m_dtr;
            err_q   <= 1'b0;
            m_req_q <= 1'b0;
            state_q <= ST_RESP;
          end else if (tmo) begin
            if (srv_x_q) x_dtr_q <= ERRDATA;
            else         f_dtr_q <= ERRDATA;
            err_q   <= 1'b1;
            m_req_q <= 1'b0;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          x_rdy_q  <= srv_x_q;
          x_err_q  <= srv_x_q & err_q;
          f_rdy_q  <= ~srv_x_q;
          f_err_q  <= ~srv_x_q & err_q;
          last_x_q <= srv_x_q;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign f_dtr  = f_dtr_q;
  assign f_rdy  = f_rdy_q;
  assign f_err  = f_err_q;
  assign x_dtr  = x_dtr_q;
  assign x_rdy  = x_rdy_q;
  assign x_err  = x_err_q;
  assign m_addr = m_addr_q;
  assign m_dtw  = m_dtw_q;
  assign m_rw   = m_rw_q;
  assign m_req  = m_req_q;

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hs32_mem_arbiter
// Directed stimulus with a scoreboard: each stimulus step pushes the bus
// issue and client response it expects; a negedge monitor pops and compares
// whenever m_req rises or a rdy pulse appears. A small memory model answers
// bus requests after mem_waits cycles with data mem_fn(addr).
// ---------------------------------------------------------------------------
module tb_hs32_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dtw;
    logic        rw;
  } bus_t;

  typedef struct {
    logic        is_x;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] f_addr;
  logic        f_req;
  logic [31:0] f_dtr;
  logic        f_rdy;
  logic [31:0] x_addr;
  logic [31:0] x_dtw;
  logic        x_rw;
  logic        x_req;
  logic [31:0] x_dtr;
  logic        x_rdy;
  logic        x_err;
  logic        f_err;
  logic [31:0] m_addr;
  logic [31:0] m_dtw;
  logic        m_rw;
  logic        m_req;
  logic [31:0] m_dtr;
  logic        m_rdy;

  int n_chk   = 0;
  int n_err   = 0;
  int n_issue = 0;
  int mem_waits = 0;
  bit mem_mute  = 1'b0;

  bus_t  bq[$];
  resp_t rq[$];

  hs32_mem_arbiter #(
    .TIMEOUT (8),
    .ERRDATA (32'hDEAD_BEEF)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .f_addr (f_addr),
    .f_req  (f_req),
    .f_dtr  (f_dtr),
    .f_rdy  (f_rdy),
    .x_addr (x_addr),
    .x_dtw  (x_dtw),
    .x_rw   (x_rw),
    .x_req  (x_req),
    .x_dtr  (x_dtr),
    .x_rdy  (x_rdy),
    .x_err  (x_err),
    .f_err  (f_err),
    .m_addr (m_addr),
    .m_dtw  (m_dtw),
    .m_rw   (m_rw),
    .m_req  (m_req),
    .m_dtr  (m_dtr),
    .m_rdy  (m_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a + 32'h1234_5578;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [31:0] d, input logic rw);
    bus_t b;
    b.addr = a; b.dtw = d; b.rw = rw;
    bq.push_back(b);
  endtask

  task automatic push_resp(input logic is_x, input logic [31:0] d, input logic err);
    resp_t r;
    r.is_x = is_x; r.data = d; r.err = err;
    rq.push_back(r);
  endtask

  // Called right after a negedge on which the request was raised; cycle n is
  // the negedge following edge n-1 after the request.
  task automatic wait_done(input bit is_x, input int budget,
                           output int c_rdy, output int c_mrdy,
                           output int c_first, output int c_last);
    c_rdy = -1; c_mrdy = -1; c_first = -1; c_last = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (m_req) begin
        if (c_first < 0) c_first = c;
        c_last = c;
      end
      if (m_rdy && c_mrdy < 0) c_mrdy = c;
      if (is_x ? x_rdy : f_rdy) begin
        c_rdy = c;
        break;
      end
    end
    n_chk++;
    if (c_rdy < 0) begin
      n_err++;
      $display("FAIL wait_done: got no rdy within %0d cycles, expected a rdy pulse", budget);
    end
  endtask

  task automatic wait_n_rdy(input int target, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < target; c++) begin
      @(negedge clk);
      if (f_rdy || x_rdy) seen++;
    end
    n_chk++;
    if (seen != target) begin
      n_err++;
      $display("FAIL wait_n_rdy: got %0d responses, expected %0d", seen, target);
    end
  endtask

  // Memory model: decides m_rdy for the coming cycle just after each edge.
  initial begin
    int wcnt;
    wcnt  = 0;
    m_rdy = 1'b0;
    m_dtr = '0;
    forever begin
      @(posedge clk);
      #1;
      m_rdy = 1'b0;
      if (!rstn || !m_req || mem_mute) begin
        wcnt = 0;
      end else if (wcnt >= mem_waits) begin
        m_rdy = 1'b1;
        m_dtr = mem_fn(m_addr);
        wcnt  = 0;
      end else begin
        wcnt++;
      end
    end
  end

  // Monitor
  logic        pf = 1'b0;
  logic        px = 1'b0;
  logic        pm = 1'b0;
  logic [31:0] s_addr = '0;
  logic [31:0] s_dtw  = '0;
  logic        s_rw   = 1'b0;
  resp_t       mr;
  bus_t        mb;

  always @(negedge clk) begin
    if (f_rdy || x_rdy) begin
      chk("rdy_exclusive", 32'(f_rdy & x_rdy), 32'd0);
      if (f_rdy) chk("f_rdy_single", 32'(pf), 32'd0);
      if (x_rdy) chk("x_rdy_single", 32'(px), 32'd0);
      if (rq.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_rdy: got f_rdy=%0b x_rdy=%0b, expected no response", f_rdy, x_rdy);
      end else begin
        mr = rq.pop_front();
        chk("resp_port", 32'(x_rdy), 32'(mr.is_x));
        chk("resp_data", x_rdy ? x_dtr : f_dtr, mr.data);
        chk("resp_err", 32'(x_rdy ? x_err : f_err), 32'(mr.err));
      end
    end
    if (m_req && !pm) begin
      n_issue++;
      if (bq.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_issue: got m_addr=0x%08h, expected no bus request", m_addr);
      end else begin
        mb = bq.pop_front();
        chk("issue_addr", m_addr, mb.addr);
        chk("issue_rw", 32'(m_rw), 32'(mb.rw));
        if (mb.rw) chk("issue_dtw", m_dtw, mb.dtw);
      end
      s_addr = m_addr;
      s_dtw  = m_dtw;
      s_rw   = m_rw;
    end else if (m_req) begin
      chk("m_addr_stable", m_addr, s_addr);
      chk("m_dtw_stable", m_dtw, s_dtw);
      chk("m_rw_stable", 32'(m_rw), 32'(s_rw));
    end
    pf = f_rdy;
    px = x_rdy;
    pm = m_req;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cr, cm, cf, cl, base;
    rstn = 1'b0; f_req = 1'b0; f_addr = '0;
    x_req = 1'b0; x_addr = '0; x_dtw = '0; x_rw = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_outputs", 32'(|{f_dtr, f_rdy, f_err, x_dtr, x_rdy, x_err,
                             m_addr, m_dtw, m_rw, m_req}), 32'd0);
    rstn = 1'b1;

    // Zero-wait fetch read
    @(negedge clk);
    push_bus(32'h100, 32'h0, 1'b0);
    push_resp(1'b0, 32'h1234_5678, 1'b0);
    f_addr = 32'h100; f_req = 1'b1;
    wait_done(1'b0, 20, cr, cm, cf, cl);
    f_req = 1'b0;
    chk("fetch_mreq_lat", 32'(cf), 32'd1);
    chk("fetch_rdy_lat", 32'(cr), 32'd3);
    chk("fetch_rdy_after_mrdy", 32'(cr - cm), 32'd2);

    // Tie from reset: X, F, X, F
    @(negedge clk);
    rstn = 1'b0;
    f_addr = 32'h300; x_addr = 32'h400; x_rw = 1'b0;
    f_req = 1'b1; x_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_bus(32'h400, 32'h0, 1'b0);
      push_bus(32'h300, 32'h0, 1'b0);
      push_resp(1'b1, 32'h1234_5978, 1'b0);
      push_resp(1'b0, 32'h1234_5878, 1'b0);
    end
    @(negedge clk);
    rstn = 1'b1;
    wait_n_rdy(4, 40);
    f_req = 1'b0; x_req = 1'b0;

    // Execute write with 4 wait cycles
    @(negedge clk);
    mem_waits = 4;
    x_addr = 32'h200; x_dtw = 32'hCAFE_F00D; x_rw = 1'b1; x_req = 1'b1;
    push_bus(32'h200, 32'hCAFE_F00D, 1'b1);
    push_resp(1'b1, 32'h1234_5778, 1'b0);
    wait_done(1'b1, 30, cr, cm, cf, cl);
    x_req = 1'b0; x_rw = 1'b0;
    chk("wr_mreq_first", 32'(cf), 32'd1);
    chk("wr_mreq_cycles", 32'(cl - cf + 1), 32'd5);
    chk("wr_rdy_after_mrdy", 32'(cr - cm), 32'd2);
    chk("f_dtr_hold", f_dtr, 32'h1234_5878);

    // Timeout: memory never answers
    @(negedge clk);
    mem_waits = 0; mem_mute = 1'b1;
    f_addr = 32'h500; f_req = 1'b1;
    push_bus(32'h500, 32'h0, 1'b0);
    push_resp(1'b0, 32'hDEAD_BEEF, 1'b1);
    wait_done(1'b0, 30, cr, cm, cf, cl);
    f_req = 1'b0;
    chk("tmo_mreq_last", 32'(cl), 32'd8);
    chk("tmo_rdy_lat", 32'(cr), 32'd10);
    chk("x_dtr_hold", x_dtr, 32'h1234_5778);
    mem_mute = 1'b0;
    @(negedge clk);
    f_addr = 32'h504; f_req = 1'b1;
    push_bus(32'h504, 32'h0, 1'b0);
    push_resp(1'b0, 32'h1234_5A7C, 1'b0);
    wait_done(1'b0, 20, cr, cm, cf, cl);
    f_req = 1'b0;
    chk("post_tmo_rdy_lat", 32'(cr), 32'd3);

    // Asynchronous reset in the middle of an execute transaction
    @(negedge clk);
    mem_waits = 4;
    x_addr = 32'h600; x_rw = 1'b0; x_req = 1'b1;
    push_bus(32'h600, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_in_exec", 32'(m_req), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_m_req", 32'(m_req), 32'd0);
    chk("arst_x_rdy", 32'(x_rdy), 32'd0);
    chk("arst_outputs", 32'(|{f_dtr, f_rdy, f_err, x_dtr, x_rdy, x_err,
                              m_addr, m_dtw, m_rw, m_req}), 32'd0);
    f_addr = 32'h700; f_req = 1'b1; mem_waits = 0;
    push_bus(32'h600, 32'h0, 1'b0);
    push_bus(32'h700, 32'h0, 1'b0);
    push_resp(1'b1, 32'h1234_5B78, 1'b0);
    push_resp(1'b0, 32'h1234_5C78, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    wait_n_rdy(2, 30);
    f_req = 1'b0; x_req = 1'b0;

    // Back-to-back fetches: next address presented during the rdy cycle
    @(negedge clk);
    base = n_issue;
    f_addr = 32'h0; f_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_bus(32'(4 * i), 32'h0, 1'b0);
      push_resp(1'b0, mem_fn(32'(4 * i)), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      wait_n_rdy(1, 20);
      if (i < 3) f_addr = f_addr + 32'd4;
      else       f_req = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("b2b_issue_count", 32'(n_issue - base), 32'd4);

    chk("bus_q_empty", 32'(bq.size()), 32'd0);
    chk("resp_q_empty", 32'(rq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
